lfsr_13: RTL and testbench

//   Free-running 13-bit Fibonacci LFSR pseudo-random source for game logic
//   (obstacle spacing/timing).
//   - Exposes the live shift-register state and its combinational next value.
//   - Also exposes a sampled output, rnd, that refreshes once every

---
 rtl/lfsr_13_if.sv | 24 ++
 rtl/lfsr_13.sv | 82 ++++++++
 tb/tb_lfsr_13.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/lfsr_13_if.sv
// Output bundle of the 13-bit LFSR random source.
//   rnd          sampled random value, refreshed once per sample period
//   random       live shift-register state
//   random_next  combinational next value of random
// master: the LFSR driving the bundle; slave: a consumer reading it.
interface lfsr_13_if #(
  parameter int WIDTH = 13
);
  logic [WIDTH-1:0] rnd;
  logic [WIDTH-1:0] random;
  logic [WIDTH-1:0] random_next;

  modport master (
    output rnd,
    output random,
    output random_next
  );

  modport slave (
    input rnd,
    input random,
    input random_next
  );
endinterface

// File: rtl/lfsr_13.sv
// Free-running 13-bit Fibonacci LFSR, polynomial x^13+x^4+x^3+x+1
// (maximal length, period 8191). It is used as a pseudo-random source for
// game logic.
//   clock        rising-edge system clock
//   reset        asynchronous, active-high; loads SEED, clears rnd and count
//   bus.random       live LFSR state (registered)
//   bus.random_next  combinational next state (pure shift, no lock-up guard)
//   bus.rnd          copy of random taken every SAMPLE_PERIOD clocks (registered)
// The tap positions are fixed for a 13-bit register.
module lfsr_13 #(
  parameter int               WIDTH         = 13,
  parameter logic [WIDTH-1:0] SEED          = 13'h000F,
  parameter int               SAMPLE_PERIOD = 13
) (
  input logic       clock,
  input logic       reset,
  lfsr_13_if.master bus
);

  // A zero seed would lock the register, so it is replaced by 1.
  localparam logic [WIDTH-1:0] SEED_SAFE = (SEED == '0) ? WIDTH'(1) : SEED;
  localparam int               CNT_W     = $clog2(SAMPLE_PERIOD + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SAMPLE_PERIOD - 1);

  logic [WIDTH-1:0] random_reg;
  logic [WIDTH-1:0] rnd_reg;
  logic [CNT_W-1:0] count_reg;

  logic [WIDTH-1:0] shift_next;
  logic [WIDTH-1:0] random_next;
  logic [CNT_W-1:0] count_next;
  logic             feedback;
  logic             sample_now;

  assign feedback = random_reg[12] ^ random_reg[3] ^ random_reg[2] ^ random_reg[0];

  // Shift toward the MSB, with the feedback bit entering at bit 0.
  assign shift_next[0] = feedback;
  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_shift
      assign shift_next[gi] = random_reg[gi-1];
    end
  endgenerate

  // The all-zero state is a fixed point of the shift. It can only be reached
  // through a fault, so recover by reloading the seed.
  always_comb begin
    random_next = shift_next;
    if (random_reg == '0) begin
      random_next = SEED_SAFE;
    end
  end

  assign sample_now = (count_reg == CNT_LAST);

  always_comb begin
    count_next = count_reg + CNT_W'(1);
    if (sample_now) begin
      count_next = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      random_reg <= SEED_SAFE;
      count_reg  <= '0;
      rnd_reg    <= '0;
    end else begin
      random_reg <= random_next;
      count_reg  <= count_next;
      // Sample the value that random takes on this same edge.
      if (sample_now) begin
        rnd_reg <= random_next;
      end
    end
  end

  assign bus.random      = random_reg;
  assign bus.random_next = shift_next;
  assign bus.rnd         = rnd_reg;

endmodule

// File: tb/tb_lfsr_13.sv
// Scoreboard bench for lfsr_13. The stimulus process pushes one expected
// entry per clock edge. The monitor pops one entry at each falling edge and
// compares it with the DUT outputs. On every cycle the monitor also checks
// that random_next is derived correctly from random.
module tb_lfsr_13;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  lfsr_13_if #(.WIDTH(13)) bus ();

  lfsr_13 #(
    .WIDTH(13),
    .SEED(13'h000F),
    .SAMPLE_PERIOD(13)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [12:0] random;
    logic [12:0] rnd;
    logic        chk_next;
    logic [12:0] next;
    logic        track;
    logic        show;
    int          tag;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int          zero_hits = 0;
  int          dup_hits  = 0;
  bit          seen [0:8191];
  logic [12:0] tab [0:12];

  function automatic logic [12:0] step_of(input logic [12:0] s);
    return {s[11:0], s[12] ^ s[3] ^ s[2] ^ s[0]};
  endfunction

  task automatic cmp(input string name, input int tag, input logic [12:0] got,
                     input logic [12:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s (edge %0d): got=%h expected=%h", name, tag, got, want);
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    for (int i = 0; i < 8192; i++) seen[i] = 1'b0;
    seen[13'h000F] = 1'b1;
    forever begin
      @(negedge clock);
      if (reset !== 1'bx) begin
        cmp("next_formula", -1, bus.random_next, step_of(bus.random));
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp("random", e.tag, bus.random, e.random);
        cmp("rnd", e.tag, bus.rnd, e.rnd);
        if (e.chk_next) cmp("random_next", e.tag, bus.random_next, e.next);
        if (e.track) begin
          if (bus.random == 13'h0) zero_hits++;
          else if (seen[bus.random]) dup_hits++;
          seen[bus.random] = 1'b1;
        end
        if (e.show) $display("edge %0d: random=%h rnd=%h", e.tag, bus.random, bus.rnd);
      end
    end
  end

  task automatic push_edge(input logic [12:0] r, input logic [12:0] s,
                           input logic chk_n, input logic [12:0] n,
                           input logic trk, input logic shw, input int tag);
    exp_t e;
    @(posedge clock);
    e.random   = r;
    e.rnd      = s;
    e.chk_next = chk_n;
    e.next     = n;
    e.track    = trk;
    e.show     = shw;
    e.tag      = tag;
    sb.push_back(e);
  endtask

  // These are the first 13 edges after reset is released. The values were
  // computed by hand from seed 000F.
  task automatic run_table(input logic trk);
    for (int i = 0; i < 13; i++) begin
      push_edge(tab[i], (i == 12) ? tab[12] : 13'h0000, 1'b0, 13'h0, trk, 1'b1, i + 1);
    end
  endtask

  task automatic drain;
    for (int k = 0; k < 8 && sb.size() != 0; k++) @(negedge clock);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d expected=0", sb.size());
    end
  endtask

  // Stimulus
  initial begin
    logic [12:0] mrand;
    logic [12:0] mrnd;

    tab[0]  = 13'h001F; tab[1]  = 13'h003F; tab[2]  = 13'h007F; tab[3]  = 13'h00FF;
    tab[4]  = 13'h01FF; tab[5]  = 13'h03FF; tab[6]  = 13'h07FF; tab[7]  = 13'h0FFF;
    tab[8]  = 13'h1FFF; tab[9]  = 13'h1FFE; tab[10] = 13'h1FFD; tab[11] = 13'h1FFA;
    tab[12] = 13'h1FF4;

    reset = 1'b1;
    // Hold reset for 2 cycles.
    push_edge(13'h000F, 13'h0000, 1'b1, 13'h001F, 1'b0, 1'b1, 0);
    push_edge(13'h000F, 13'h0000, 1'b1, 13'h001F, 1'b0, 1'b1, 0);
    #2 reset = 1'b0;

    // Check the first 13 edges and the first rnd sample.
    run_table(1'b1);

    // Free-run to a full period. rnd updates every 13th edge (26, 39, ...).
    mrand = 13'h1FF4;
    mrnd  = 13'h1FF4;
    for (int n = 14; n <= 8191; n++) begin
      mrand = step_of(mrand);
      if (n % 13 == 0) mrnd = mrand;
      push_edge(mrand, mrnd, 1'b0, 13'h0, (n <= 8190), (n <= 27), n);
    end
    drain();
    cmp("period_return", 8191, bus.random, 13'h000F);
    cmp("never_zero", 8191, 13'(zero_hits), 13'h0);
    cmp("all_distinct", 8191, 13'(dup_hits), 13'h0);

    // Run a few more edges, then apply reset between clock edges.
    for (int n = 8192; n <= 8198; n++) begin
      mrand = step_of(mrand);
      if (n % 13 == 0) mrnd = mrand;
      push_edge(mrand, mrnd, 1'b0, 13'h0, 1'b0, 1'b1, n);
    end
    drain();
    #1 reset = 1'b1;
    #1;
    cmp("async_random", 0, bus.random, 13'h000F);
    cmp("async_rnd", 0, bus.rnd, 13'h0000);
    cmp("async_next", 0, bus.random_next, 13'h001F);
    push_edge(13'h000F, 13'h0000, 1'b1, 13'h001F, 1'b0, 1'b1, 0);
    push_edge(13'h000F, 13'h0000, 1'b1, 13'h001F, 1'b0, 1'b1, 0);
    #2 reset = 1'b0;

    // After reset is released, the sequence starts again from the beginning.
    run_table(1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
